// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a contiguous address range of a single-port,
// one-cycle-latency, read-first block RAM and streams the words out on a
// valid/ready interface, sustaining one word per cycle while the sink is ready.
// Optional feature macro: BRAM_STREAM_CLEAR_EN -- when defined, each read also
// writes CLEAR_VALUE back to the same address (scanout-and-clear).
module bram_stream_reader #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

`ifdef BRAM_STREAM_CLEAR_EN
    localparam logic CLEAR_EN = 1'b1;
`else
    localparam logic CLEAR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     rem_q, rem_d;        // addresses still to issue
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]              infl_v_q, infl_v_d;  // [0]: address on RAM, [1]: data on mem_rdata
    logic [1:0]              infl_last_q, infl_last_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q [4];
    logic [DATA_WIDTH-1:0]   fifo_data_d [4];
    logic [3:0]              fifo_last_q, fifo_last_d;
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [2:0]              fifo_count_q, fifo_count_d;

    logic                    issue_s;
    logic                    issue_last_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    last_hs_s;
    logic                    credit_ok_s;
    logic [1:0]              infl_cnt_s;

    assign infl_cnt_s  = {1'b0, infl_v_q[0]} + {1'b0, infl_v_q[1]};
    // Words buffered plus words in flight never exceed the FIFO depth.
    assign credit_ok_s = ({1'b0, fifo_count_q} + {2'b00, infl_cnt_s}) < 4'd4;
    assign push_s      = infl_v_q[1];
    assign pop_s       = (fifo_count_q != 3'd0) && m_ready;
    assign last_hs_s   = pop_s && fifo_last_q[rd_ptr_q];

    // Command sequencing: accept, issue addresses under credit, drain, report done.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        // The first address goes out on the accepting edge.
                        issue_s      = 1'b1;
                        issue_last_s = (length == (ADDR_WIDTH+1)'(1));
                        addr_d       = base_addr;
                        rem_d        = length - (ADDR_WIDTH+1)'(1);
                        state_d      = issue_last_s ? ST_WAIT : ST_ISSUE;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rem_q == '0) begin
                    state_d = ST_WAIT;
                end else if (credit_ok_s) begin
                    issue_s      = 1'b1;
                    issue_last_s = (rem_q == (ADDR_WIDTH+1)'(1));
                    addr_d       = addr_q + ADDR_WIDTH'(1);
                    rem_d        = rem_q - (ADDR_WIDTH+1)'(1);
                    state_d      = issue_last_s ? ST_WAIT : ST_ISSUE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (last_hs_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Write-back of CLEAR_VALUE alongside each issued read when clearing is built in.
    always_comb begin
        if (CLEAR_EN && issue_s) begin
            we_d    = 1'b1;
            wdata_d = CLEAR_VALUE;
        end else begin
            we_d    = 1'b0;
            wdata_d = '0;
        end
    end

    // In-flight tracking mirrors the two-cycle path from address to mem_rdata.
    always_comb begin
        infl_v_d    = {infl_v_q[0], issue_s};
        infl_last_d = {infl_last_q[0], issue_last_s};
    end

    // Output FIFO: push returning RAM words, pop on handshake.
    always_comb begin
        fifo_data_d  = fifo_data_q;
        fifo_last_d  = fifo_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push_s) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_last_d[wr_ptr_q] = infl_last_q[1];
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_count_d = fifo_count_q + 3'd1;
            2'b01:   fifo_count_d = fifo_count_q - 3'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // State, counters, pipeline and FIFO storage; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            infl_v_q     <= 2'b00;
            infl_last_q  <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q  <= 4'b0000;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            infl_v_q     <= infl_v_d;
            infl_last_q  <= infl_last_d;
            fifo_data_q  <= fifo_data_d;
            fifo_last_q  <= fifo_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign m_valid   = (fifo_count_q != 3'd0);
    assign m_data    = fifo_data_q[rd_ptr_q];
    assign m_last    = fifo_last_q[rd_ptr_q] & m_valid;

endmodule
